// File: rtl/mu0_boot_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mu0_boot_ctrl: loads an MU0 program image from a host, then runs the CPU   |
// | until STP or a cycle budget. Optional macro: BOOT_BREAKPOINT_EN.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mu0_boot_ctrl #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 16,
  parameter int LOAD_WORDS = 1024,
  parameter int MAX_CYCLES = 200,
  parameter int RST_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              host_valid,
  input  logic [DATA_W-1:0] host_data,
  input  logic              host_last,
  output logic              host_ready,
  output logic              cpu_rst,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_data_out,
  input  logic              cpu_memory_read,
  input  logic              cpu_memory_write,
  input  logic              cpu_fetch,
`ifdef BOOT_BREAKPOINT_EN
  input  logic              bp_valid,
  input  logic [ADDR_W-1:0] bp_addr,
  output logic              bp_hit,
`endif
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [15:0]       cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_RESET_CPU = 3'd2,
    S_RUN       = 3'd3,
    S_HALTED    = 3'd4,
    S_TIMEOUT   = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] C_LAST_PTR  = ADDR_W'(LOAD_WORDS - 1);
  localparam logic [15:0]       C_LAST_RST  = 16'(RST_CYCLES - 1);
  localparam logic [15:0]       C_LAST_RUN  = 16'(MAX_CYCLES - 1);
  localparam logic [3:0]        C_OP_STP    = 4'h7;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [15:0]         rst_cnt_q, rst_cnt_d;
  logic [15:0]         cycle_q, cycle_d;
  logic                done_q, done_d;
  logic                timeout_q, timeout_d;
  logic                bp_hit_q, bp_hit_d;
  logic                stp_fetch;
  logic                bp_match;

  // Opcode is the top nibble of the word the CPU is fetching this cycle.
  assign stp_fetch = cpu_fetch && (mem_rdata[DATA_W-1 -: 4] == C_OP_STP);

`ifdef BOOT_BREAKPOINT_EN
  assign bp_match = bp_valid && cpu_fetch && (cpu_address == bp_addr);
  assign bp_hit   = bp_hit_q;
`else
  logic unused_bp;
  assign bp_match  = 1'b0;
  assign unused_bp = bp_hit_q;
`endif

  logic unused_rdata;
  assign unused_rdata = ^mem_rdata[DATA_W-5:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      rst_cnt_q <= '0;
      cycle_q   <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      bp_hit_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rst_cnt_q <= rst_cnt_d;
      cycle_q   <= cycle_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      bp_hit_q  <= bp_hit_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rst_cnt_d   = rst_cnt_q;
    cycle_d     = cycle_q;
    done_d      = done_q;
    timeout_d   = timeout_q;
    bp_hit_d    = bp_hit_q;
    host_ready  = 1'b0;
    cpu_rst     = 1'b1;
    mem_address = '0;
    mem_wdata   = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;

    case (state_q)
      S_IDLE, S_HALTED, S_TIMEOUT: begin
        if (start) begin
          state_d   = S_LOAD;
          ptr_d     = '0;
          cycle_d   = '0;
          done_d    = 1'b0;
          timeout_d = 1'b0;
          bp_hit_d  = 1'b0;
        end
      end

      S_LOAD: begin
        host_ready  = 1'b1;
        mem_address = ptr_q;
        mem_wdata   = host_data;
        mem_write   = host_valid;
        if (host_valid) begin
          ptr_d = ptr_q + 1'b1;
          // Stopping at the last slot means the pointer never wraps onto word 0.
          if (host_last || (ptr_q == C_LAST_PTR)) begin
            state_d   = S_RESET_CPU;
            rst_cnt_d = '0;
          end
        end
      end

      S_RESET_CPU: begin
        if (rst_cnt_q == C_LAST_RST) begin
          state_d = S_RUN;
          cycle_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + 16'd1;
        end
      end

      S_RUN: begin
        cpu_rst     = 1'b0;
        mem_address = cpu_address;
        mem_wdata   = cpu_data_out;
        mem_read    = cpu_memory_read;
        mem_write   = cpu_memory_write;
        if (cycle_q != 16'hFFFF) begin
          cycle_d = cycle_q + 16'd1;
        end
        if (stp_fetch) begin
          state_d = S_HALTED;
          done_d  = 1'b1;
        end else if (bp_match) begin
          state_d  = S_HALTED;
          bp_hit_d = 1'b1;
        end else if (cycle_q == C_LAST_RUN) begin
          state_d   = S_TIMEOUT;
          timeout_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy        = (state_q != S_IDLE) && (state_q != S_HALTED) && (state_q != S_TIMEOUT);
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign cycle_count = cycle_q;

endmodule
`default_nettype wire

// File: tb/tb_mu0_boot_ctrl.sv
`default_nettype none
// Bench for mu0_boot_ctrl: host loader, small MU0 model and 4K memory,
// with scoreboards for memory writes and run results.
module tb_mu0_boot_ctrl;
  localparam int ADDR_W = 12, DATA_W = 16, LOAD_WORDS = 1024;
  localparam int MAX_CYCLES = 200, RST_CYCLES = 2;

  logic clk = 1'b0;
  logic rst, start, host_valid, host_last;
  logic [15:0] host_data;
  wire  host_ready, cpu_rst, mem_read, mem_write, busy, done, timeout;
  wire  [11:0] mem_address;
  wire  [15:0] mem_wdata, mem_rdata, cycle_count;
  logic [11:0] cpu_address;
  logic [15:0] cpu_data_out;
  logic cpu_memory_read, cpu_memory_write, cpu_fetch;
  wire  bp_obs;
`ifdef BOOT_BREAKPOINT_EN
  logic bp_valid = 1'b0;
  logic [11:0] bp_addr = '0;
  wire  bp_hit;
  assign bp_obs = bp_hit;
`else
  assign bp_obs = 1'b0;
`endif

  always #5 clk = ~clk;

  mu0_boot_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOAD_WORDS(LOAD_WORDS),
                  .MAX_CYCLES(MAX_CYCLES), .RST_CYCLES(RST_CYCLES)) dut (
    .clk(clk), .rst(rst), .start(start),
    .host_valid(host_valid), .host_data(host_data), .host_last(host_last),
    .host_ready(host_ready), .cpu_rst(cpu_rst),
    .cpu_address(cpu_address), .cpu_data_out(cpu_data_out),
    .cpu_memory_read(cpu_memory_read), .cpu_memory_write(cpu_memory_write),
    .cpu_fetch(cpu_fetch),
`ifdef BOOT_BREAKPOINT_EN
    .bp_valid(bp_valid), .bp_addr(bp_addr), .bp_hit(bp_hit),
`endif
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata), .busy(busy), .done(done),
    .timeout(timeout), .cycle_count(cycle_count)
  );

  // 4K x 16 memory, asynchronous read
  logic [15:0] mem [4096];
  assign mem_rdata = mem[mem_address];
  always @(posedge clk) if (mem_write) mem[mem_address] <= mem_wdata;

  // Minimal MU0: fetch cycle then execute cycle
  logic [11:0] pc;
  logic [15:0] ir, acc;
  logic        exec;
  always_comb begin
    cpu_fetch        = !exec;
    cpu_address      = exec ? ir[11:0] : pc;
    cpu_memory_read  = !exec || (ir[15:12] == 4'h0) || (ir[15:12] == 4'h2) || (ir[15:12] == 4'h3);
    cpu_memory_write = exec && (ir[15:12] == 4'h1);
    cpu_data_out     = acc;
  end
  always @(posedge clk) begin
    if (cpu_rst) begin
      pc <= '0; acc <= '0; ir <= '0; exec <= 1'b0;
    end else if (!exec) begin
      ir <= mem_rdata; pc <= pc + 12'd1; exec <= 1'b1;
    end else begin
      case (ir[15:12])
        4'h0: acc <= mem_rdata;
        4'h2: acc <= acc + mem_rdata;
        4'h3: acc <= acc - mem_rdata;
        4'h4: pc <= ir[11:0];
        4'h5: if (!acc[15]) pc <= ir[11:0];
        4'h6: if (acc != 16'd0) pc <= ir[11:0];
        default: ;
      endcase
      exec <= 1'b0;
    end
  end

  int checks = 0, errors = 0;
  logic [31:0] exp_wr[$];
  logic [31:0] exp_res[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitor
  always @(negedge clk) begin
    if (!rst && mem_write) begin
      if (exp_wr.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected write: addr %0h data %0h, expected none", mem_address, mem_wdata);
      end else begin
        check("mem write {addr,data}", 32'({mem_address, mem_wdata}), exp_wr.pop_front());
      end
    end
  end

  // Result monitor: fires on the rising edge of done|timeout
  logic fin_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst && (done || timeout) && !fin_prev) begin
      if (exp_res.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected result: done %0b timeout %0b, expected none", done, timeout);
      end else begin
        check("run result {done,timeout,bp,count}", 32'({done, timeout, bp_obs, cycle_count}),
              exp_res.pop_front());
      end
    end
    fin_prev = done || timeout;
  end

  logic [15:0] img_stp[$]  = '{16'h0004, 16'h2005, 16'h7000, 16'h0000, 16'h0003};
  logic [15:0] img_loop[$] = '{16'h4000};

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input logic last, input int addr);
    exp_wr.push_back(32'({addr[11:0], d}));
    host_valid = 1'b1; host_data = d; host_last = last;
    check("host_ready in load", 32'(host_ready), 32'd1);
    tick();
    host_valid = 1'b0; host_last = 1'b0;
  endtask

  task automatic load_image(input logic [15:0] img[$]);
    for (int i = 0; i < img.size(); i++) send(img[i], i == img.size() - 1, i);
  endtask

  task automatic check_rst_len();
    int n = 0;
    check("host_ready after load", 32'(host_ready), 32'd0);
    while (cpu_rst && n < 10) begin n++; tick(); end
    check("cpu_rst high cycles", 32'(n), 32'(RST_CYCLES));
  endtask

  task automatic wait_fin(input int budget);
    int n = 0;
    while (!(done || timeout) && n < budget) begin tick(); n++; end
    if (!(done || timeout)) begin
      checks++; errors++;
      $display("FAIL run end: no done/timeout after %0d cycles, expected one", budget);
    end
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; host_valid = 1'b0; host_last = 1'b0; host_data = '0;
    tick(); tick();
    // Reset state
    check("reset cpu_rst", 32'(cpu_rst), 32'd1);
    check("reset host_ready", 32'(host_ready), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset timeout", 32'(timeout), 32'd0);
    check("reset cycle_count", 32'(cycle_count), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset mem strobes", 32'({mem_read, mem_write}), 32'd0);
    rst = 1'b0;
    tick();

    // STP program: halts on the fetch of 7000 at address 2, five run cycles in
    exp_res.push_back(32'({1'b1, 1'b0, 1'b0, 16'd5}));
    do_start();
    load_image(img_stp);
    check_rst_len();
    wait_fin(100);
    repeat (3) tick();
    check("halt count frozen", 32'(cycle_count), 32'd5);
    check("halt cpu_rst", 32'(cpu_rst), 32'd1);
    check("halt strobes", 32'({mem_read, mem_write}), 32'd0);
    check("halt busy", 32'(busy), 32'd0);
    check("halt done held", 32'(done), 32'd1);

    // JMP 0 loop: timeout exactly MAX_CYCLES clocks after cpu_rst falls
    exp_res.push_back(32'({1'b0, 1'b1, 1'b0, 16'd200}));
    do_start();
    check("start clears done", 32'(done), 32'd0);
    load_image(img_loop);
    check_rst_len();
    n = 0;
    while (!timeout && n < 300) begin tick(); n++; end
    check("timeout latency", 32'(n), 32'd200);
    check("timeout done low", 32'(done), 32'd0);
    tick();

    // Full-depth load with gapped host_valid and no host_last
    exp_res.push_back(32'({1'b0, 1'b1, 1'b0, 16'd200}));
    do_start();
    for (int i = 0; i < LOAD_WORDS; i++) begin
      send({4'h4, 12'(i)}, 1'b0, i);
      if (i != LOAD_WORDS - 1) tick();
    end
    check("busy after full load", 32'(busy), 32'd1);
    check_rst_len();
    check("write queue drained", 32'(exp_wr.size()), 32'd0);
    wait_fin(300);

    // Asynchronous reset mid-run
    do_start();
    load_image(img_loop);
    check_rst_len();
    n = 0;
    while (cycle_count != 16'd50 && n < 100) begin tick(); n++; end
    check("reached run cycle 50", 32'(cycle_count), 32'd50);
    #2 rst = 1'b1;
    #1;
    check("abort cpu_rst", 32'(cpu_rst), 32'd1);
    check("abort cycle_count", 32'(cycle_count), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort host_ready", 32'(host_ready), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    exp_res.push_back(32'({1'b1, 1'b0, 1'b0, 16'd5}));
    do_start();
    load_image(img_stp);
    check_rst_len();
    wait_fin(100);

`ifdef BOOT_BREAKPOINT_EN
    // Breakpoint on the fetch at address 1 (third run cycle)
    bp_valid = 1'b1; bp_addr = 12'h001;
    exp_res.push_back(32'({1'b0, 1'b0, 1'b1, 16'd3}));
    do_start();
    check("start clears bp_hit", 32'(bp_hit), 32'd0);
    load_image(img_stp);
    check_rst_len();
    wait_fin(100);
    // Breakpoint on the STP word itself: STP takes priority
    bp_addr = 12'h002;
    exp_res.push_back(32'({1'b1, 1'b0, 1'b0, 16'd5}));
    do_start();
    load_image(img_stp);
    check_rst_len();
    wait_fin(100);
    bp_valid = 1'b0;
`endif

    repeat (3) tick();
    check("write queue empty", 32'(exp_wr.size()), 32'd0);
    check("result queue empty", 32'(exp_res.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
